burst_read_responder: RTL and testbench
=======================================

# burst_read_responder

AXI4 read-channel burst responder backed by a word-addressed on-chip memory. It is the memory-side end of the instruction cache's refill port: it accepts the cache's `araddr/arlen/arburst` request, waits a programmable access latency, and streams `arlen+1` beats back with `rlast` on the final beat. It also supports simulation and SoC bring-up, with a single-cycle preload write port used to load program images.

## Interface
Parameters:
- `ADDR_BASE`, 32'h3000_0000: byte address of memory word 0.
- `MEM_WORDS_DIG`, 12: memory holds 2^MEM_WORDS_DIG 32-bit words.
- `LATENCY`, 4: cycles from AR handshake to first `rvalid`. Legal range 1..255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `araddr` in 32: burst start byte address. Bits [1:0] are ignored.
- `arvalid` in 1: address valid.
- `arready` out 1: address ready.
- `arlen` in 8: beats minus one.
- `arburst` in 2: 00 = FIXED-as-INCR, 01 = INCR, 10 = WRAP, 11 = reserved.
- `rdata` out 32: beat data.
- `rresp` out 2: 00 = OKAY, 10 = SLVERR, 11 = DECERR.
- `rvalid` out 1: beat valid.
- `rready` in 1: beat accepted.
- `rlast` out 1: final beat of the burst.
- `wr_en` in 1: preload write strobe.
- `wr_addr` in 32: preload byte address. Bits [1:0] are ignored.
- `wr_data` in 32: preload word.

## Operation
- State machine: IDLE, DELAY, BEAT.
- `arready` = (state == IDLE).
- **IDLE:** on `arvalid && arready`:
  - latch `araddr[31:2]`, `arlen`, `arburst`;
  - clear the beat counter and load the delay counter.
  - Next state is DELAY, or BEAT directly when LATENCY == 1.
- **DELAY:** count down. Enter BEAT so that `rvalid` first rises exactly LATENCY cycles after the handshake edge.
- **BEAT:** `rvalid` = 1. On `rvalid && rready`:
  - if beat == len, return to IDLE;
  - otherwise increment the beat counter and advance the address.
- **Address advance:**
  - `arburst` 00 and 01: +1 word. The cache issues 00 and expects incrementing data.
  - `arburst` 10: wrap inside the aligned (len+1)-word window. The window base is the start word with its low log2(len+1) bits cleared.
- **Response per beat:**
  - word index = (addr − ADDR_BASE) >> 2, computed in 32-bit unsigned wrap-around arithmetic.
  - Index ≥ 2^MEM_WORDS_DIG: `rresp` = 11, `rdata` = 0.
  - `arburst` = 11, or WRAP with len ∉ {1, 3, 7, 15}: `rresp` = 10 and `rdata` = 0 on every beat. The burst still runs its full len+1 beats.
  - Otherwise: `rresp` = 00, `rdata` = mem[index].
  - The range check is evaluated per beat, so an INCR burst that runs off the end switches from OKAY to DECERR mid-burst.
- `rlast` = `rvalid` && (beat == len).
- **Preload:**
  - `wr_en` writes `wr_data` to mem[index] at the clock edge, only when state == IDLE and index is in range. Otherwise the write is silently dropped.
  - A preload write and an AR handshake in the same IDLE cycle both take effect. The burst sees the new data.
- Memory contents are not cleared by reset.

## Timing
- **Reset** (cycle `rst` high and the following edge):
  - state goes to IDLE;
  - `rvalid` = 0, `rlast` = 0, `rdata` = 0, `rresp` = 00;
  - `arready` = 0 while `rst` is high, and 1 from the first cycle after reset deasserts.
- **Reset mid-burst:** the burst is aborted and no further beats are issued. The next request is handled normally.
- **Throughput:** one beat per cycle while `rready` = 1.
- A burst of N beats at full `rready` occupies LATENCY + N cycles from the handshake. `arready` returns to 1 the cycle after the `rlast` handshake.
- **Backpressure:** while `rvalid && !rready`, `rdata`, `rresp` and `rlast` are held stable. `rvalid` never drops until the beat is accepted.
- `rvalid` and `rlast` depend only on state and registers. `rdata` is read combinationally from the latched address, with no dependency on `rready` or `arvalid`.
- `arvalid` asserted outside IDLE is ignored and not queued. The requester holds it until `arready`.
- LATENCY counter and beat counter are 8 bits. `arlen` = 255 yields 256 beats with no overflow.

## Test plan
- **INCR burst:** LATENCY = 4. Preload 0x3000_0000..0x3000_000C with 0x11, 0x22, 0x33, 0x44. Issue `araddr` 0x3000_0000, `arlen` 3, `arburst` 00, `rready` = 1, handshake at cycle 0.
  - Required: `rvalid` in cycles 4–7 with data 0x11, 0x22, 0x33, 0x44 and `rresp` 00.
  - `rlast` only in cycle 7; `arready` = 1 in cycle 8.
- **Backpressure:** same burst with `rready` = 1,0,0,1,0,1,1.
  - Required: each beat is held (data, `rlast` unchanged) until accepted.
  - Exactly 4 accepted beats in order.
- **WRAP burst:** `araddr` 0x3000_0008, `arlen` 3, `arburst` 10.
  - Required data: 0x33, 0x44, 0x11, 0x22.
  - `arlen` 2 with WRAP gives 3 beats of `rresp` 10, `rdata` 0.
- **Range crossing:** `araddr` = ADDR_BASE + 4·2^MEM_WORDS_DIG − 4, `arlen` 1, INCR.
  - Beat 0: `rresp` 00 with the stored word.
  - Beat 1: `rresp` 11, `rdata` 0, `rlast` = 1.
- **Reset mid-burst:** `arlen` 7, assert `rst` for 1 cycle after 2 accepted beats.
  - Required: `rvalid` = 0 from the reset cycle on.
  - A new 2-beat burst completes correctly afterwards.
- **Write gating:** during an active burst, `wr_en` to 0x3000_0000 with 0xDEAD is dropped, and a later read returns 0x11.
  - The same write issued in IDLE is accepted, and a later read returns 0xDEAD.

Source files
------------

// File: rtl/burst_read_responder.sv
// AXI4 read-channel burst responder over a word-addressed on-chip memory.
// Serves instruction-cache refills after a fixed access latency; a preload port fills the memory.
module burst_read_responder #(
    parameter logic [31:0] ADDR_BASE     = 32'h3000_0000,
    parameter int          MEM_WORDS_DIG = 12,
    parameter int          LATENCY       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    typedef enum logic [1:0] {IDLE, DELAY, BEAT} state_t;

    localparam logic [7:0] DELAY_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [7:0]  len_q, beat_q, delay_q;
    logic [1:0]  burst_q;
    logic [31:0] mem [2**MEM_WORDS_DIG];

    logic        ar_hs, r_hs, last_beat;
    logic [31:0] word_idx, wr_idx;
    logic        in_range, wr_in_range, legal_wrap, bad_burst;
    logic [29:0] cur_word, wrap_mask, next_word;

    // Outputs are masked during the reset cycle so nothing is offered while rst is high.
    assign arready   = (state == IDLE) && !rst;
    assign rvalid    = (state == BEAT) && !rst;
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign last_beat = (beat_q == len_q);
    assign rlast     = rvalid && last_beat;

    assign word_idx    = (addr_q - ADDR_BASE) >> 2;
    assign in_range    = (word_idx >> MEM_WORDS_DIG) == 32'd0;
    assign wr_idx      = ((wr_addr & 32'hFFFF_FFFC) - ADDR_BASE) >> 2;
    assign wr_in_range = (wr_idx >> MEM_WORDS_DIG) == 32'd0;

    assign legal_wrap = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    assign bad_burst  = (burst_q == 2'b11) || ((burst_q == 2'b10) && !legal_wrap);

    // WRAP only touches the bits covered by len, so the address stays inside its aligned window.
    assign cur_word  = addr_q[31:2];
    assign wrap_mask = {22'd0, len_q};

    always_comb begin
        next_word = cur_word + 30'd1;
        if (burst_q == 2'b10)
            next_word = (cur_word & ~wrap_mask) | ((cur_word + 30'd1) & wrap_mask);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ar_hs) state_next = (LATENCY == 1) ? BEAT : DELAY;
            DELAY:   if (delay_q == 8'd0) state_next = BEAT;
            BEAT:    if (r_hs && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        rresp = 2'b00;
        if (rvalid) begin
            if (!in_range)
                rresp = 2'b11;
            else if (bad_burst)
                rresp = 2'b10;
            else
                rdata = mem[word_idx[MEM_WORDS_DIG-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            burst_q <= 2'b00;
            beat_q  <= 8'd0;
            delay_q <= 8'd0;
        end else begin
            state <= state_next;
            if (ar_hs) begin
                addr_q  <= araddr & 32'hFFFF_FFFC;
                len_q   <= arlen;
                burst_q <= arburst;
                beat_q  <= 8'd0;
                delay_q <= DELAY_LOAD;
            end else if (state == DELAY) begin
                delay_q <= delay_q - 8'd1;
            end else if (r_hs && !last_beat) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= {next_word, 2'b00};
            end
        end
    end

    // Preload writes land only while idle; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE) && wr_in_range)
            mem[wr_idx[MEM_WORDS_DIG-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_burst_read_responder.sv
// Self-checking bench for burst_read_responder: directed test-plan bursts plus randomized
// bursts checked against a word-level reference model of the memory and burst address rules.
module tb_burst_read_responder;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DIG   = 12;
    localparam int          WORDS = 4096;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        rlast;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    int n_vec = 0;
    int n_miscompare = 0;

    logic [31:0] model_mem [WORDS];
    logic [31:0] exp_data [256];
    logic [1:0]  exp_resp [256];

    logic        hs_wr_en = 1'b0, mid_wr_en = 1'b0;
    logic [31:0] hs_wr_addr = '0, hs_wr_data = '0, mid_wr_addr = '0, mid_wr_data = '0;

    burst_read_responder #(
        .ADDR_BASE(BASE), .MEM_WORDS_DIG(DIG), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscompare++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_index(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) - BASE) >> 2;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] idx;
        idx = word_index(a);
        if (idx < WORDS) model_mem[idx[11:0]] = d;
    endtask

    // Expected beats from the burst rules: INCR walks words, WRAP rotates within an aligned window.
    task automatic build_expected(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] n, sw, base, w, idx;
        n    = 32'(len) + 32'd1;
        sw   = addr >> 2;
        base = sw - (sw % n);
        for (int b = 0; b <= int'(len); b++) begin
            if (burst == 2'b10) w = base + ((sw - base + 32'(b)) % n);
            else                w = sw + 32'(b);
            idx = word_index(w << 2);
            if (idx >= WORDS) begin
                exp_resp[b] = 2'b11; exp_data[b] = 32'd0;
            end else if (burst == 2'b11 || (burst == 2'b10 && !(n inside {2, 4, 8, 16}))) begin
                exp_resp[b] = 2'b10; exp_data[b] = 32'd0;
            end else begin
                exp_resp[b] = 2'b00; exp_data[b] = model_mem[idx[11:0]];
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arvalid = 1'b1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_write(a, d);
        tick();
        wr_en = 1'b0;
    endtask

    // Starts in an idle cycle; ends in the idle cycle after the rlast handshake.
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [31:0] rr_pat, input bit rr_rand);
        int beat, cyc;
        applyStimulus(addr, len, burst);
        if (hs_wr_en) begin
            wr_en = 1'b1; wr_addr = hs_wr_addr; wr_data = hs_wr_data;
            model_write(hs_wr_addr, hs_wr_data);
        end
        build_expected(addr, len, burst);
        #1;
        checkOutput("arready_idle", arready, 1);
        tick();
        arvalid = 1'b0;
        wr_en   = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            if (c == 1 && mid_wr_en) begin
                wr_en = 1'b1; wr_addr = mid_wr_addr; wr_data = mid_wr_data;
            end
            #1;
            checkOutput("rvalid_delay", rvalid, 0);
            checkOutput("arready_busy", arready, 0);
            tick();
            wr_en = 1'b0;
        end
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 4 * (int'(len) + 1) + 20) begin
            rready = rr_rand ? ($urandom_range(0, 3) != 0) : ((cyc < 32) ? rr_pat[cyc] : 1'b1);
            #1;
            checkOutput("rvalid_beat", rvalid, 1);
            checkOutput("rdata", rdata, exp_data[beat]);
            checkOutput("rresp", rresp, exp_resp[beat]);
            checkOutput("rlast", rlast, (beat == int'(len)));
            if (rvalid && rready) beat++;
            cyc++;
            tick();
        end
        rready = 1'b0;
        checkOutput("beats_accepted", beat, int'(len) + 1);
        #1;
        checkOutput("arready_after", arready, 1);
        checkOutput("rvalid_after", rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          kind;
        int          sw;
        logic [7:0]  wrap_lens [4];

        wrap_lens[0] = 8'd1; wrap_lens[1] = 8'd3; wrap_lens[2] = 8'd7; wrap_lens[3] = 8'd15;

        tick();
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rresp", rresp, 0);
        checkOutput("rst_arready", arready, 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("arready_post_rst", arready, 1);

        for (int i = 0; i < WORDS; i++) preload(BASE + 32'(4 * i), $urandom);
        preload(BASE + 32'h0, 32'h11);
        preload(BASE + 32'h4, 32'h22);
        preload(BASE + 32'h8, 32'h33);
        preload(BASE + 32'hC, 32'h44);
        preload(BASE + 32'(4 * WORDS), 32'hBAD0_0001);
        preload(BASE - 32'h4, 32'hBAD0_0002);

        $display("[TB] INCR and backpressure");
        do_burst(BASE, 8'd3, 2'b00, 32'hFFFF_FFFF, 1'b0);
        do_burst(BASE, 8'd3, 2'b00, 32'hFFFF_FFE9, 1'b0);

        $display("[TB] WRAP");
        do_burst(BASE + 32'h8, 8'd3, 2'b10, 32'hFFFF_FFFF, 1'b0);
        do_burst(BASE + 32'h8, 8'd2, 2'b10, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] range crossing");
        do_burst(BASE + 32'(4 * WORDS) - 32'h4, 8'd1, 2'b01, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] reset mid-burst");
        applyStimulus(BASE + 32'h80, 8'd7, 2'b01);
        build_expected(BASE + 32'h80, 8'd7, 2'b01);
        tick();
        arvalid = 1'b0;
        repeat (LAT - 1) tick();
        rready = 1'b1;
        #1;
        checkOutput("mid_beat0", rdata, exp_data[0]);
        tick();
        #1;
        checkOutput("mid_beat1", rdata, exp_data[1]);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_rvalid", rvalid, 0);
        checkOutput("mid_rst_rlast", rlast, 0);
        checkOutput("mid_rst_rdata", rdata, 0);
        checkOutput("mid_rst_arready", arready, 0);
        tick();
        rst = 1'b0;
        rready = 1'b0;
        #1;
        checkOutput("post_rst_arready", arready, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_rst_rvalid", rvalid, 0);
            tick();
        end
        do_burst(BASE + 32'h40, 8'd1, 2'b01, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] write gating");
        mid_wr_en = 1'b1; mid_wr_addr = BASE; mid_wr_data = 32'hDEAD;
        do_burst(BASE + 32'h100, 8'd3, 2'b01, 32'hFFFF_FFFF, 1'b0);
        mid_wr_en = 1'b0;
        do_burst(BASE, 8'd0, 2'b01, 32'hFFFF_FFFF, 1'b0);
        preload(BASE, 32'hDEAD);
        do_burst(BASE, 8'd0, 2'b00, 32'hFFFF_FFFF, 1'b0);
        hs_wr_en = 1'b1; hs_wr_addr = BASE + 32'h14; hs_wr_data = $urandom;
        do_burst(BASE + 32'h14, 8'd0, 2'b01, 32'hFFFF_FFFF, 1'b0);
        hs_wr_en = 1'b0;

        $display("[TB] randomized bursts");
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: begin
                    burst = 2'(kind);
                    len   = 8'($urandom_range(0, 20));
                    sw    = $urandom_range(0, WORDS - 1);
                end
                2: begin
                    burst = 2'b10;
                    len   = ($urandom_range(0, 1) == 0) ? wrap_lens[$urandom_range(0, 3)]
                                                         : 8'($urandom_range(0, 20));
                    sw    = $urandom_range(0, WORDS - 1);
                end
                default: begin
                    burst = 2'b11;
                    len   = 8'($urandom_range(0, 20));
                    sw    = $urandom_range(0, WORDS - 1 - int'(len));
                end
            endcase
            a = BASE + 32'(4 * sw) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) preload(BASE + 32'(4 * $urandom_range(0, WORDS - 1)), $urandom);
            do_burst(a, len, burst, 32'hFFFF_FFFF, 1'b1);
        end

        $display("[TB] 256-beat burst");
        do_burst(BASE + 32'h400, 8'd255, 2'b01, 32'hFFFF_FFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
